// File: rtl/move_input_queue.sv
// Turns direction/start button levels into discrete move events with frame-timed
// auto-repeat, and buffers them in a small FIFO drained by a valid/ready handshake.
module move_input_queue #(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_start,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       start_pulse,
    output logic [7:0] drop_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [5:0]     DELAY_C = 6'(REPEAT_DELAY);
    localparam logic [5:0]     RATE_C  = 6'(REPEAT_RATE);

    logic [3:0]       level;
    logic [3:0]       prev;
    logic [3:0]       press;
    logic             start_prev;

    logic [1:0]       hold_dir;
    logic             hold_active;
    logic [5:0]       rep_cnt;
    logic             rep_phase;

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic             press_any;
    logic [1:0]       press_dir;
    logic             hold_level;
    logic [5:0]       tick_cnt;
    logic [5:0]       rep_target;
    logic             rep_hit;
    logic             rep_fire;
    logic             ev_valid;
    logic [1:0]       ev_dir;
    logic             pop;
    logic             push;
    logic             drop;

    // Bit index of level/prev equals the direction code.
    assign level = {btn_left, btn_down, btn_right, btn_up};
    assign press = level & ~prev;

    always_comb begin
        press_any = |press;
        press_dir = 2'd0;
        if (press[0])      press_dir = 2'd0;
        else if (press[1]) press_dir = 2'd1;
        else if (press[2]) press_dir = 2'd2;
        else if (press[3]) press_dir = 2'd3;
    end

    assign hold_level = level[hold_dir];
    assign tick_cnt   = rep_cnt + 6'd1;
    assign rep_target = rep_phase ? RATE_C : DELAY_C;
    assign rep_hit    = hold_active && hold_level && frame_tick && (tick_cnt == rep_target);
    // A fresh press always wins over a repeat landing in the same cycle.
    assign rep_fire   = rep_hit && !press_any;

    assign ev_valid   = enable && (press_any || rep_fire);
    assign ev_dir     = press_any ? press_dir : hold_dir;

    assign move_valid = (count != '0);
    assign move_dir   = mem[rd_ptr];
    assign pop        = move_valid && move_ready;
    assign push       = ev_valid && ((count < DEPTH_C) || pop);
    assign drop       = ev_valid && !push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev        <= 4'hF;
            start_prev  <= 1'b1;
            start_pulse <= 1'b0;
        end else begin
            prev        <= level;
            start_prev  <= btn_start;
            start_pulse <= btn_start && !start_prev && enable;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            hold_dir    <= 2'd0;
            hold_active <= 1'b0;
            rep_cnt     <= 6'd0;
            rep_phase   <= 1'b0;
        end else if (press_any) begin
            hold_dir    <= press_dir;
            hold_active <= 1'b1;
            rep_cnt     <= 6'd0;
            rep_phase   <= 1'b0;
        end else if (hold_active && !hold_level) begin
            hold_active <= 1'b0;
        end else if (hold_active && frame_tick) begin
            if (rep_hit) begin
                rep_cnt   <= 6'd0;
                rep_phase <= 1'b1;
            end else begin
                rep_cnt   <= tick_cnt;
            end
        end
    end

    // Storage is cleared on reset so the head reads as direction 0 afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 2'd0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (!enable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ev_dir;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                        drop_count <= 8'd0;
        else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end

endmodule

// File: tb/tb_move_input_queue.sv
// Directed self-checking bench for move_input_queue using default parameters
// (DEPTH 4, repeat delay 20 ticks, repeat rate 6 ticks).
module tb_move_input_queue;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       enable;
    logic       btn_up, btn_right, btn_down, btn_left;
    logic       btn_start;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       start_pulse;
    logic [7:0] drop_count;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    move_input_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .enable     (enable),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_start  (btn_start),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .start_pulse(start_pulse),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dirs bit order is {left, down, right, up}; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic [3:0] dirs, input logic start_v,
                                 input logic ready_v, input int n);
        btn_up     = dirs[0];
        btn_right  = dirs[1];
        btn_down   = dirs[2];
        btn_left   = dirs[3];
        btn_start  = start_v;
        move_ready = ready_v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        frame_tick = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0, 2);
        checkOutput("reset_valid", {7'd0, move_valid}, 8'd0);
        checkOutput("reset_dir", {6'd0, move_dir}, 8'd0);
        checkOutput("reset_start", {7'd0, start_pulse}, 8'd0);
        checkOutput("reset_drop", drop_count, 8'd0);

        $display("[TB] single press");
        rst_n = 1'b1;
        enable = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1);
        checkOutput("single_valid", {7'd0, move_valid}, 8'd1);
        checkOutput("single_dir", {6'd0, move_dir}, 8'd3);
        applyStimulus(4'b1000, 1'b0, 1'b0, 2);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("single_drained", {7'd0, move_valid}, 8'd0);

        $display("[TB] start pulse");
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("start_hi", {7'd0, start_pulse}, 8'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("start_lo", {7'd0, start_pulse}, 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);

        $display("[TB] priority and fill");
        applyStimulus(4'b0101, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        checkOutput("fill_drop", drop_count, 8'd1);
        checkOutput("fill_valid", {7'd0, move_valid}, 8'd1);
        checkOutput("drain0", {6'd0, move_dir}, 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("drain1", {6'd0, move_dir}, 8'd1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("drain2", {6'd0, move_dir}, 8'd3);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("drain3", {6'd0, move_dir}, 8'd2);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("drain_empty", {7'd0, move_valid}, 8'd0);

        $display("[TB] full with pop");
        applyStimulus(4'b0010, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        checkOutput("full_head", {6'd0, move_dir}, 8'd1);
        applyStimulus(4'b0100, 1'b0, 1'b1, 1);
        checkOutput("fullpop_drop", drop_count, 8'd1);
        checkOutput("fullpop_head", {6'd0, move_dir}, 8'd2);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("fullpop_q1", {6'd0, move_dir}, 8'd3);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("fullpop_q2", {6'd0, move_dir}, 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("fullpop_q3", {6'd0, move_dir}, 8'd2);
        checkOutput("fullpop_q3_valid", {7'd0, move_valid}, 8'd1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1);
        checkOutput("fullpop_empty", {7'd0, move_valid}, 8'd0);

        $display("[TB] auto-repeat");
        pops = 0;
        applyStimulus(4'b0010, 1'b0, 1'b1, 1);
        if (move_valid) begin
            pops++;
            checkOutput("rep_dir", {6'd0, move_dir}, 8'd1);
        end
        for (int k = 1; k <= 40; k++) begin
            for (int c = 0; c < 4; c++) begin
                frame_tick = (c == 0);
                applyStimulus(4'b0010, 1'b0, 1'b1, 1);
                if (move_valid) begin
                    pops++;
                    checkOutput("rep_dir", {6'd0, move_dir}, 8'd1);
                end
            end
            if (k == 19) checkOutput("rep_before_delay", 8'(pops), 8'd1);
            if (k == 20) checkOutput("rep_at_delay", 8'(pops), 8'd2);
        end
        checkOutput("rep_total", 8'(pops), 8'd5);
        for (int k = 0; k < 40; k++) begin
            frame_tick = (k % 4 == 0);
            applyStimulus(4'b0000, 1'b0, 1'b1, 1);
            if (move_valid) pops++;
        end
        frame_tick = 1'b0;
        checkOutput("rep_after_release", 8'(pops), 8'd5);

        $display("[TB] enable gating");
        applyStimulus(4'b0001, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        checkOutput("gate_queued", {7'd0, move_valid}, 8'd1);
        enable = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        checkOutput("gate_flush", {7'd0, move_valid}, 8'd0);
        checkOutput("gate_drop_kept", drop_count, 8'd1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 2);
        enable = 1'b1;
        applyStimulus(4'b0001, 1'b0, 1'b0, 2);
        checkOutput("gate_held_up", {7'd0, move_valid}, 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1);
        checkOutput("gate_repress_valid", {7'd0, move_valid}, 8'd1);
        checkOutput("gate_repress_dir", {6'd0, move_dir}, 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        enable = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("gate_start", {7'd0, start_pulse}, 8'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("gate_start2", {7'd0, start_pulse}, 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        enable = 1'b1;

        $display("[TB] reset hold");
        rst_n = 1'b0;
        applyStimulus(4'b0100, 1'b0, 1'b0, 2);
        checkOutput("rsthold_drop", drop_count, 8'd0);
        rst_n = 1'b1;
        applyStimulus(4'b0100, 1'b0, 1'b0, 2);
        checkOutput("rsthold_noevent", {7'd0, move_valid}, 8'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1);
        checkOutput("rsthold_valid", {7'd0, move_valid}, 8'd1);
        checkOutput("rsthold_dir", {6'd0, move_dir}, 8'd2);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("midrst_pre_start", {7'd0, start_pulse}, 8'd1);
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b0, 1);
        checkOutput("midrst_valid", {7'd0, move_valid}, 8'd0);
        checkOutput("midrst_dir", {6'd0, move_dir}, 8'd0);
        checkOutput("midrst_start", {7'd0, start_pulse}, 8'd0);
        checkOutput("midrst_drop", drop_count, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_input_queue.md
# move_input_queue

Sits between the combined button/gamepad levels and `game_logic`. It turns level inputs into discrete move events, adds frame-timed auto-repeat for a held direction, and buffers moves in a small FIFO. The FIFO is drained through a valid/ready handshake, so a press arriving while a move animates or a frame is pending is never lost. It also emits a one-cycle start pulse.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `REPEAT_DELAY`, 20: frame ticks a direction must be held before the first repeat; 1..63.
- `REPEAT_RATE`, 6: frame ticks between subsequent repeats; 1..63.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse per frame (vsync rising edge).
- `enable`  in  1  high when gameplay accepts moves (welcome screen not shown).
- `btn_up`, `btn_right`, `btn_down`, `btn_left`  in  1 each  debounced, combined direction levels.
- `btn_start`  in  1  start level.
- `move_ready`  in  1  consumer accepts head entry this cycle.
- `move_valid`  out  1  FIFO non-empty.
- `move_dir`  out  2  head direction: 0 up, 1 right, 2 down, 3 left.
- `start_pulse`  out  1  one-cycle pulse on start rising edge.
- `drop_count`  out  8  saturating count of events lost to a full FIFO.

## Operation
- Edge detect: `prev[3:0]` and `start_prev` register the inputs every cycle. Press = level & ~prev. Reset loads all prev bits to 1, so a button held through reset needs a release first.
- Several presses in one cycle: one event is pushed, chosen by priority up > right > down > left. The others are discarded.
- Held direction `hold_dir` / `hold_active`:
  - An accepted press sets `hold_dir`, sets `hold_active`, and clears `rep_cnt` (6-bit) and `rep_phase` (0 = delay, 1 = rate).
  - If the `hold_dir` level is low, `hold_active` clears. Releasing other directions has no effect.
  - On each `frame_tick` with `hold_active`, `rep_cnt` increments.
  - Delay phase: when `rep_cnt` reaches REPEAT_DELAY, a repeat event with `hold_dir` is pushed, `rep_cnt` goes to 0 and `rep_phase` goes to 1.
  - Rate phase: the same happens when `rep_cnt` reaches REPEAT_RATE.
- Same-cycle press and repeat: the press wins and the repeat is dropped. This does not count as a drop.
- FIFO: 2-bit entries with rd/wr pointers and a count of width log2(DEPTH)+1.
  - Push when an event exists and (count < DEPTH, or a pop happens in the same cycle).
  - Pop on `move_valid & move_ready`.
  - Full with no pop: the event is discarded and `drop_count` increments, saturating at 255.
- `enable` low:
  - FIFO flushes: pointers and count go to 0, and `move_valid` drops the next cycle.
  - `hold_active` clears and no events are generated.
  - Prev registers keep tracking, so a button held across the `enable` rise produces no event.
  - `drop_count` is unaffected.
- `start_pulse` = `btn_start & ~start_prev & enable`, registered.

## Timing
- Reset values: `move_valid` 0, `move_dir` 0, `start_pulse` 0, `drop_count` 0, FIFO empty, `hold_active` 0, `rep_cnt` 0, `rep_phase` 0.
- Press sampled high in cycle N (prev low): the entry is written at the clock ending N, and `move_valid` is 1 in N+1 when the FIFO was empty.
- `move_dir` is stable while `move_valid` is high and `move_ready` is low.
- After a pop at the end of cycle N, the next entry (if any) is presented in N+1.
- `start_pulse` is high for exactly cycle N+1 after a start edge in N.
- First repeat: on the REPEAT_DELAY-th `frame_tick` after the press, counting ticks strictly after the press cycle. Later repeats: every REPEAT_RATE ticks.
- Press and `frame_tick` in the same cycle: the tick is not counted.
- Reset asserted mid-operation discards all state at the next edge, including queued moves.

## Test plan
- Single press: reset, `enable`=1, pulse `btn_left` high for 3 cycles with `move_ready`=0 -> `move_valid`=1 one cycle after the edge, `move_dir`=3, exactly one entry. `move_ready`=1 for one cycle -> `move_valid`=0 next cycle.
- Priority and fill: DEPTH=4, `move_ready`=0. Press up+down together, then right, left, down, up as separate presses -> queue holds 0,1,3,2 and `drop_count`=1. Draining with `move_ready`=1 yields 0,1,3,2 in order.
- Auto-repeat: hold `btn_right` for 40 `frame_tick`s with defaults and `move_ready`=1 -> events at press, tick 20, 26, 32, 38, i.e. 5 pops all with dir 1. Release -> no further events.
- Full with pop: FIFO full, new press and pop in the same cycle -> count stays 4, `drop_count` unchanged, new entry appears last.
- Enable gating: queue 2 moves, drop `enable` -> `move_valid`=0 next cycle. Hold `btn_up` while raising `enable` -> no event until release and re-press. `btn_start` edge with `enable`=0 -> no `start_pulse`.
- Reset hold: `btn_down` high through reset release -> no event. Release, then press -> one event with dir 2. Assert `rst_n`=0 with 3 queued moves -> all outputs at reset values next cycle.
